// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer for the single-cycle CPU.
// Drives a clock enable (cpu_en) to the datapath rather than gating the
// clock, issues PC-load strobes from the switches and freezes the core on
// an exception while capturing the EPC.
//
// Handshake: there is no valid/ready pair here. The datapath advances by
// one instruction on every rising SYS_clk edge where cpu_en=1; exc_flag and
// halt_flag are only meaningful in those cycles. pc_load is a one-cycle
// strobe that means "datapath PC <= pc_load_val on the next edge".
//
// Optional feature: define CPU_RUN_CTRL_BREAKPOINT_EN to add a PC
// breakpoint comparator (bp_addr, bp_en inputs, bp_hit output). The
// default build has neither the ports nor the compare logic.
module cpu_run_ctrl #(
    parameter int PC_W     = 8,
    parameter int CYC_W    = 16,
    parameter int STEP_LEN = 1
) (
    input  logic             SYS_clk,
    input  logic             SYS_rst,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             load_btn,
    input  logic [PC_W-1:0]  pc_sw,
    input  logic [PC_W-1:0]  pc_cur,
    input  logic             exc_flag,
    input  logic             halt_flag,
    output logic             cpu_en,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_val,
    output logic [PC_W-1:0]  epc,
    output logic             exc_led,
    output logic [2:0]       state,
    output logic [CYC_W-1:0] cyc_cnt
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             bp_hit
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_HALT = 3'd3,
        S_EXC  = 3'd4,
        S_LOAD = 3'd5
    } state_t;

    localparam logic [7:0] STEP_INIT = 8'(STEP_LEN);

    state_t     state_q;
    state_t     next_state;
    logic [7:0] step_cnt;
    logic [7:0] step_nxt;
    logic       capture_epc;
    logic       en_q;
    logic       run_q;
    logic       step_q;
    logic       load_q;
    logic       run_e;
    logic       step_e;
    logic       load_e;
    logic       bp_match;

    assign run_e  = run_btn & ~run_q;
    assign step_e = step_btn & ~step_q;
    assign load_e = load_btn & ~load_q;
    assign state  = state_q;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Set for the first enabled cycle after leaving IDLE so a breakpointed
    // instruction can be resumed without tripping the same breakpoint.
    logic bp_skip;

    // A breakpoint blocks the current RUN cycle unless an exception wins.
    assign bp_match = (state_q == S_RUN) && bp_en && (pc_cur == bp_addr)
                      && !bp_skip && !exc_flag;
    assign cpu_en   = en_q & ~bp_match;

    // Skip flag and one-cycle hit pulse.
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            bp_skip <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            bp_skip <= (state_q == S_IDLE) &&
                       ((next_state == S_RUN) || (next_state == S_STEP));
            bp_hit  <= bp_match;
        end
    end
`else
    assign bp_match = 1'b0;
    assign cpu_en   = en_q;
`endif

    // Button history for rising-edge detection.
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            run_q  <= 1'b0;
            step_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            run_q  <= run_btn;
            step_q <= step_btn;
            load_q <= load_btn;
        end
    end

    // Next-state logic: one request per cycle, load > step > run.
    always_comb begin
        next_state  = state_q;
        step_nxt    = step_cnt;
        capture_epc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_e) begin
                    next_state = S_LOAD;
                end else if (step_e) begin
                    next_state = S_STEP;
                    step_nxt   = STEP_INIT;
                end else if (run_e) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (exc_flag) begin
                    next_state  = S_EXC;
                    capture_epc = 1'b1;
                end else if (bp_match) begin
                    next_state = S_IDLE;
                end else if (halt_flag) begin
                    next_state = S_HALT;
                end else if (run_e) begin
                    next_state = S_IDLE;
                end
            end
            S_STEP: begin
                step_nxt = step_cnt - 8'd1;
                if (exc_flag) begin
                    next_state  = S_EXC;
                    capture_epc = 1'b1;
                end else if (halt_flag) begin
                    next_state = S_HALT;
                end else if (step_cnt <= 8'd1) begin
                    next_state = S_IDLE;
                end
            end
            S_HALT: begin
                if (load_e) next_state = S_LOAD;
            end
            S_EXC: begin
                if (load_e) next_state = S_LOAD;
            end
            S_LOAD: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            state_q  <= S_IDLE;
            step_cnt <= 8'd0;
            en_q     <= 1'b0;
            pc_load  <= 1'b0;
            exc_led  <= 1'b0;
        end else begin
            state_q  <= next_state;
            step_cnt <= step_nxt;
            en_q     <= (next_state == S_RUN) || (next_state == S_STEP);
            pc_load  <= (next_state == S_LOAD);
            exc_led  <= (next_state == S_EXC);
        end
    end

    // Load value and EPC capture.
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            pc_load_val <= '0;
            epc         <= '0;
        end else begin
            if (next_state == S_LOAD && state_q != S_LOAD) pc_load_val <= pc_sw;
            if (capture_epc) epc <= pc_cur;
        end
    end

    // Executed-instruction counter: cleared on entering LOAD, saturating.
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            cyc_cnt <= '0;
        end else if (next_state == S_LOAD) begin
            cyc_cnt <= '0;
        end else if (cpu_en && (cyc_cnt != {CYC_W{1'b1}})) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

endmodule
